// File: rtl/life_step_if.sv
// ---------------------------------------------------------------------------
// life_step_if
// Purpose : groups the control, seed-write and display-read signals of the
//           Game-of-Life step engine into one bundle.
// Signals : i_frame_tick  - one-cycle pulse per frame
//           i_run         - auto-step enable
//           i_step_now    - one-cycle manual step request
//           i_seed_valid  - seed write strobe
//           i_seed_row    - seed target row
//           i_seed_data   - seed row contents (bit x = column x)
//           o_seed_ready  - seed write will be accepted this cycle
//           i_rd_x/i_rd_y - display read coordinate
//           o_rd_alive    - front-bank cell at (i_rd_x, i_rd_y)
//           o_busy        - generation in progress
//           o_gen_done    - one-cycle pulse when a generation completes
//           o_gen_count   - completed generations (wrapping)
// Modports: master drives the i_* signals, slave (the engine) drives o_*.
// ---------------------------------------------------------------------------
interface life_step_if #(
  parameter int GRID_W = 16,
  parameter int GEN_W  = 16
);
  logic              i_frame_tick;
  logic              i_run;
  logic              i_step_now;
  logic              i_seed_valid;
  logic [3:0]        i_seed_row;
  logic [GRID_W-1:0] i_seed_data;
  logic              o_seed_ready;
  logic [3:0]        i_rd_x;
  logic [3:0]        i_rd_y;
  logic              o_rd_alive;
  logic              o_busy;
  logic              o_gen_done;
  logic [GEN_W-1:0]  o_gen_count;

  modport master (
    output i_frame_tick, i_run, i_step_now, i_seed_valid, i_seed_row,
           i_seed_data, i_rd_x, i_rd_y,
    input  o_seed_ready, o_rd_alive, o_busy, o_gen_done, o_gen_count
  );

  modport slave (
    input  i_frame_tick, i_run, i_step_now, i_seed_valid, i_seed_row,
           i_seed_data, i_rd_x, i_rd_y,
    output o_seed_ready, o_rd_alive, o_busy, o_gen_done, o_gen_count
  );
endinterface

// File: rtl/life_step_engine.sv
// ---------------------------------------------------------------------------
// life_step_engine
// Purpose : double-buffered 16x16 Game-of-Life (B3/S23, dead edges) engine.
//           The front bank is displayed through a combinational read port;
//           the back bank is filled one row per clock while computing, then
//           the banks swap in a single cycle.
// Ports   : clk   - system clock
//           rst_n - asynchronous active-low reset
//           bus   - life_step_if.slave (control, seed write, display read,
//                   status outputs)
// ---------------------------------------------------------------------------
module life_step_engine #(
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 16,
  parameter int STEP_DIV = 60,
  parameter int GEN_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  life_step_if.slave bus
);
  localparam int ROW_W = 4;
  localparam int CNT_W = $clog2(STEP_DIV);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(GRID_H - 1);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_SWAP} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [GRID_W-1:0] r_bank0 [GRID_H];
  logic [GRID_W-1:0] r_bank1 [GRID_H];
  logic              r_bank_sel;      // 0: bank0 is front, 1: bank1 is front
  logic              r_pending;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic [ROW_W-1:0]  r_row;
  logic [GEN_W-1:0]  r_gen_count;

  logic              w_tick;
  logic              w_tick_wrap;
  logic              w_request;
  logic              w_start;
  logic              w_seed_ready;
  logic              w_seed_accept;
  logic [GRID_W-1:0] w_rd_row;
  logic [GRID_W-1:0] w_up;
  logic [GRID_W-1:0] w_cur;
  logic [GRID_W-1:0] w_dn;
  logic [GRID_W+1:0] w_up_pad;
  logic [GRID_W+1:0] w_cur_pad;
  logic [GRID_W+1:0] w_dn_pad;
  logic [GRID_W-1:0] w_next_row;

  // ---------------- request handling ----------------
  assign w_tick      = bus.i_frame_tick && bus.i_run;
  assign w_tick_wrap = w_tick && (r_frame_cnt == LAST_TICK);
  assign w_request   = w_tick_wrap || bus.i_step_now;
  assign w_start     = (r_state == S_IDLE) && r_pending;
  assign w_seed_accept = bus.i_seed_valid && w_seed_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_tick) begin
      r_frame_cnt <= w_tick_wrap ? '0 : r_frame_cnt + 1'b1;
    end
  end

  // One-deep request flag; a request arriving in the cycle that consumes
  // the flag is merged into the generation being started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else if (w_start) begin
      r_pending <= 1'b0;
    end else if (w_request) begin
      r_pending <= 1'b1;
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (r_pending) w_state_next = S_COMPUTE;
      S_COMPUTE: if (r_row == LAST_ROW) w_state_next = S_SWAP;
      S_SWAP:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.o_busy     = 1'b0;
    bus.o_gen_done = 1'b0;
    w_seed_ready   = 1'b0;
    case (r_state)
      S_IDLE:    w_seed_ready = !r_pending;
      S_COMPUTE: bus.o_busy = 1'b1;
      S_SWAP:    begin bus.o_busy = 1'b1; bus.o_gen_done = 1'b1; end
      default:   ;
    endcase
  end

  assign bus.o_seed_ready = w_seed_ready;
  assign bus.o_gen_count  = r_gen_count;

  // ---------------- row index, bank select, generation count ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row       <= '0;
      r_bank_sel  <= 1'b0;
      r_gen_count <= '0;
    end else begin
      if (w_start) r_row <= '0;
      else if (r_state == S_COMPUTE) r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
      if (r_state == S_SWAP) begin
        r_bank_sel  <= ~r_bank_sel;
        r_gen_count <= r_gen_count + 1'b1;
      end
    end
  end

  // ---------------- front-bank neighbourhood of the current row ----------------
  // Rows outside the grid read as zero; the padding bits supply dead columns.
  assign w_cur = r_bank_sel ? r_bank1[r_row] : r_bank0[r_row];
  assign w_up  = (r_row == '0) ? '0 :
                 (r_bank_sel ? r_bank1[r_row - 1'b1] : r_bank0[r_row - 1'b1]);
  assign w_dn  = (r_row == LAST_ROW) ? '0 :
                 (r_bank_sel ? r_bank1[r_row + 1'b1] : r_bank0[r_row + 1'b1]);

  assign w_up_pad  = {1'b0, w_up,  1'b0};
  assign w_cur_pad = {1'b0, w_cur, 1'b0};
  assign w_dn_pad  = {1'b0, w_dn,  1'b0};

  // Column x of the row sits at padded bit x+1.
  generate
    for (genvar gi = 0; gi < GRID_W; gi++) begin : g_cell
      logic [3:0] w_cnt;
      assign w_cnt = 4'(w_up_pad[gi])  + 4'(w_up_pad[gi+1])  + 4'(w_up_pad[gi+2]) +
                     4'(w_cur_pad[gi])                       + 4'(w_cur_pad[gi+2]) +
                     4'(w_dn_pad[gi])  + 4'(w_dn_pad[gi+1])  + 4'(w_dn_pad[gi+2]);
      assign w_next_row[gi] = (w_cnt == 4'd3) || (w_cur_pad[gi+1] && (w_cnt == 4'd2));
    end
  endgenerate

  // ---------------- state banks ----------------
  // Seeds always go to the front bank, computed rows to the back bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < GRID_H; i++) begin
        r_bank0[i] <= '0;
        r_bank1[i] <= '0;
      end
    end else begin
      if (w_seed_accept) begin
        if (r_bank_sel) r_bank1[bus.i_seed_row] <= bus.i_seed_data;
        else            r_bank0[bus.i_seed_row] <= bus.i_seed_data;
      end
      if (r_state == S_COMPUTE) begin
        if (r_bank_sel) r_bank0[r_row] <= w_next_row;
        else            r_bank1[r_row] <= w_next_row;
      end
    end
  end

  // ---------------- display read port ----------------
  assign w_rd_row       = r_bank_sel ? r_bank1[bus.i_rd_y] : r_bank0[bus.i_rd_y];
  assign bus.o_rd_alive = w_rd_row[bus.i_rd_x];

endmodule

// File: tb/tb_life_step_engine.sv
// ---------------------------------------------------------------------------
// tb_life_step_engine
// Randomised and directed stimulus for life_step_engine. Each issued step
// pushes the expected next grid, generation count and gen_done cycle into a
// queue; an independent monitor pops an entry on every gen_done pulse and
// compares timing, count and the full displayed grid.
// ---------------------------------------------------------------------------
module tb_life_step_engine;
  localparam int W   = 16;
  localparam int H   = 16;
  localparam int DIV = 60;

  typedef struct packed {
    logic [255:0] grid;
    logic [31:0]  due;
    logic [15:0]  gc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t         sb[$];
  logic [255:0] model_grid;
  logic [15:0]  model_gc;
  int           last_due;

  life_step_if #(.GRID_W(W), .GEN_W(16)) bus ();

  life_step_engine #(.GRID_W(W), .GRID_H(H), .STEP_DIV(DIV), .GEN_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #500 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: count the eight neighbours of every cell, dead outside grid.
  function automatic logic [255:0] life(input logic [255:0] g);
    logic [255:0] n;
    n = '0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int c;
        c = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            int yy;
            int xx;
            yy = y + dy;
            xx = x + dx;
            if (!(dy == 0 && dx == 0) && yy >= 0 && yy < H && xx >= 0 && xx < W)
              c += int'(g[yy*W + xx]);
          end
        end
        n[y*W + x] = (c == 3) || (g[y*W + x] && c == 2);
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic read_grid(output logic [255:0] g);
    g = '0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        bus.i_rd_x = 4'(x);
        bus.i_rd_y = 4'(y);
        #1;
        g[y*W + x] = bus.o_rd_alive;
      end
    end
  endtask

  // Request sampled at posedge number t; the engine is free one cycle after
  // the previous gen_done, and a generation takes 17 cycles from there.
  task automatic push_step(input int t);
    exp_t e;
    int   due;
    due = ((t > last_due + 1) ? t : last_due + 1) + 17;
    model_grid = life(model_grid);
    model_gc   = model_gc + 16'd1;
    e.grid = model_grid;
    e.due  = 32'(due);
    e.gc   = model_gc;
    sb.push_back(e);
    last_due = due;
  endtask

  task automatic step();
    @(negedge clk);
    bus.i_step_now = 1'b1;
    push_step(cyc + 1);
    @(negedge clk);
    bus.i_step_now = 1'b0;
  endtask

  task automatic seed(input int r, input logic [15:0] d);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.o_seed_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("seed_ready_timeout", 256'(0), 256'(1));
    bus.i_seed_valid = 1'b1;
    bus.i_seed_row   = 4'(r);
    bus.i_seed_data  = d;
    model_grid[r*W +: W] = d;
    @(negedge clk);
    bus.i_seed_valid = 1'b0;
  endtask

  task automatic load(input logic [255:0] g);
    for (int r = 0; r < H; r++) seed(r, g[r*W +: W]);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((sb.size() != 0 || bus.o_busy) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) check("gen_done_timeout", 256'(sb.size()), 256'(0));
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every gen_done must match the next queued expectation.
  initial begin
    exp_t         e;
    logic [255:0] g;
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_gen_done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_gen_done at cycle %0d: got pulse expected none", cyc);
        end else begin
          e = sb.pop_front();
          check("gen_done_cycle", 256'(cyc), 256'(e.due));
          @(negedge clk);
          check("gen_count", 256'(bus.o_gen_count), 256'(e.gc));
          read_grid(g);
          check("grid", g, e.grid);
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    failures++;
    $display("FAIL watchdog: got no end after 20000 cycles expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] g;
    logic [255:0] blinker;
    logic [255:0] block;
    bus.i_frame_tick = 1'b0;
    bus.i_run        = 1'b0;
    bus.i_step_now   = 1'b0;
    bus.i_seed_valid = 1'b0;
    bus.i_seed_row   = 4'd0;
    bus.i_seed_data  = 16'd0;
    bus.i_rd_x       = 4'd0;
    bus.i_rd_y       = 4'd0;
    model_grid = '0;
    model_gc   = '0;
    last_due   = -100;
    blinker = '0;
    blinker[7*W +: W] = 16'h01C0;
    block = '0;
    block[4*W +: W] = 16'h0030;
    block[5*W +: W] = 16'h0030;

    // Reset state
    #100;
    check("reset_busy", 256'(bus.o_busy), 256'(0));
    check("reset_gen_done", 256'(bus.o_gen_done), 256'(0));
    check("reset_seed_ready", 256'(bus.o_seed_ready), 256'(1));
    check("reset_gen_count", 256'(bus.o_gen_count), 256'(0));
    read_grid(g);
    check("reset_grid", g, 256'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Frame divider: no steps with run=0, then steps on ticks 60 and 120
    load(blinker);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); bus.i_frame_tick = 1'b1;
      @(negedge clk); bus.i_frame_tick = 1'b0;
      repeat (8) @(negedge clk);
    end
    bus.i_run = 1'b1;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      bus.i_frame_tick = 1'b1;
      if (i % DIV == 0) push_step(cyc + 1);
      @(negedge clk); bus.i_frame_tick = 1'b0;
      repeat (8) @(negedge clk);
    end
    bus.i_run = 1'b0;
    wait_done();

    // Blinker oscillates
    step(); wait_done();
    step(); wait_done();

    // Corner, no wrap across columns or rows
    g = '0;
    g[0*W +: W] = 16'hC000;
    g[1*W +: W] = 16'h8000;
    load(g);
    step(); wait_done();
    g = '0;
    g[15*W + 15] = 1'b1;
    load(g);
    step(); wait_done();

    // Busy protection and one extra generation for a step during COMPUTE
    for (int r = 0; r < H; r++) g[r*W +: W] = 16'($urandom) | 16'($urandom);
    load(g);
    step();
    repeat (2) @(negedge clk);
    check("busy_seed_ready", 256'(bus.o_seed_ready), 256'(0));
    check("busy_flag", 256'(bus.o_busy), 256'(1));
    bus.i_seed_valid = 1'b1;
    bus.i_seed_row   = 4'd3;
    bus.i_seed_data  = 16'hFFFF;
    @(negedge clk);
    bus.i_seed_valid = 1'b0;
    bus.i_step_now = 1'b1;
    push_step(cyc + 1);
    @(negedge clk);
    bus.i_step_now = 1'b0;
    wait_done();

    // Still life
    load(block);
    for (int i = 0; i < 5; i++) begin
      step(); wait_done();
    end

    // Random soups, sometimes with a second request mid-COMPUTE
    for (int n = 0; n < 6; n++) begin
      for (int r = 0; r < H; r++) g[r*W +: W] = 16'($urandom) & 16'($urandom);
      load(g);
      step();
      if ($urandom_range(1, 0) == 1) begin
        repeat ($urandom_range(10, 1)) @(negedge clk);
        bus.i_step_now = 1'b1;
        push_step(cyc + 1);
        @(negedge clk);
        bus.i_step_now = 1'b0;
      end
      wait_done();
    end

    // Reset in the middle of COMPUTE
    load(blinker);
    step();
    repeat (8) @(negedge clk);
    check("pre_reset_busy", 256'(bus.o_busy), 256'(1));
    #100;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midreset_busy", 256'(bus.o_busy), 256'(0));
    check("midreset_gen_count", 256'(bus.o_gen_count), 256'(0));
    check("midreset_seed_ready", 256'(bus.o_seed_ready), 256'(1));
    read_grid(g);
    check("midreset_grid", g, 256'(0));
    model_grid = '0;
    model_gc   = '0;
    last_due   = -100;
    @(negedge clk);
    rst_n = 1'b1;
    step(); wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/life_step_engine.md
Name: life_step_engine

Overview:
- Sequential Game-of-Life generation engine on a 16x16 grid. Feeds the VGA pixel stage.
- Holds two state banks: front (displayed) and back (being computed).
- Counts vsync-derived frame ticks and computes one new generation per STEP_DIV frames, one row per clock.
- Swaps banks atomically when the generation is complete.
- Exposes a combinational cell read port for the display and a row-wide seed write port.

Parameters:
- GRID_W, 16, columns per row; one bit per cell, bit x = column x.
- GRID_H, 16, number of rows.
- STEP_DIV, 60, frame ticks per generation step.
- GEN_W, 16, generation counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- frame_tick  in  1  one-cycle pulse per frame (rising vsync, synchronised upstream).
- run  in  1  1 = auto-step enabled; 0 = frame counter holds.
- step_now  in  1  one-cycle manual step request; honoured regardless of run.
- seed_valid  in  1  write seed_data into front-bank row seed_row.
- seed_row  in  4  target row index.
- seed_data  in  GRID_W  row contents.
- seed_ready  out  1  1 when a seed write is accepted (state IDLE, no pending step).
- rd_x  in  4  display read column.
- rd_y  in  4  display read row.
- rd_alive  out  1  front-bank cell (rd_x, rd_y), combinational, no latency.
- busy  out  1  1 in COMPUTE or SWAP.
- gen_done  out  1  one-cycle pulse in the SWAP cycle.
- gen_count  out  GEN_W  generations completed, wraps modulo 2^GEN_W.

Behaviour:
- Reset (rst_n=0, asynchronous): both banks all-zero, bank select=0, state IDLE, frame counter 0, pending=0, gen_count 0, gen_done 0, busy 0, seed_ready 1.
- Frame counter:
  - Increments on frame_tick when run=1.
  - On reaching STEP_DIV-1 with a tick, it resets to 0 and sets pending.
  - It keeps counting during COMPUTE.
- step_now sets pending.
- pending is one deep: further requests while pending=1 are merged, not queued.
- States:
  - IDLE -> COMPUTE when pending=1. Clear pending and load row index r=0.
  - COMPUTE: each cycle, back[r] = next(front[r-1], front[r], front[r+1]). Rows outside 0..GRID_H-1 read as zero. r increments. After r=GRID_H-1, go to SWAP.
  - SWAP (one cycle): toggle bank select, pulse gen_done, gen_count+1, go to IDLE.
- Latency: from the IDLE cycle with pending=1 to gen_done is GRID_H+1 cycles (17 with defaults). rd_alive shows the new generation from the cycle after SWAP.
- Next-state rule is standard B3/S23:
  - Neighbour count 0..8 (4-bit) over the 8 surrounding cells.
  - Alive next if count==3, or if alive now and count==2.
- Edges are dead, not toroidal: column -1 and column GRID_W read 0; no wrap across columns or rows.
- Seed writes:
  - Accepted only when seed_ready=1 and write front[seed_row] on that edge.
  - Ignored (no state change) while busy or pending.
  - A seed write in the same cycle as the IDLE->COMPUTE transition is ignored.
- Simultaneous frame_tick and step_now give a single pending request.
- rd_alive is unaffected by COMPUTE: the front bank is read-only outside IDLE seed writes.
- Reset mid-COMPUTE: immediate return to the reset state; the partial back bank is discarded (cleared).

Test Plan:
1. Blinker: seed row7=0x01C0, all other rows 0, pulse step_now -> gen_done after 17 cycles, rows 6,7,8=0x0080, gen_count=1. Second step -> row7=0x01C0 again, gen_count=2.
2. Corner/no-wrap: seed row0=0xC000, row1=0x8000, step -> rows 0 and 1 = 0xC000, bit 0 of every row 0. Separately, seed a lone cell at row15 bit15, step -> all zero.
3. Frame divider: run=1, 120 frame_tick pulses spaced 10 cycles apart -> exactly 2 gen_done pulses, on ticks 60 and 120. With run=0 -> none.
4. Busy protection: step_now, then 3 cycles later seed_valid row3=0xFFFF -> seed_ready=0 at that time, row 3 unchanged after gen_done. A step_now during COMPUTE runs exactly one extra generation afterwards.
5. Still life: block (rows 4,5=0x0030) stepped 5 times -> unchanged, gen_count=5, rd_alive(4,4)=1 and rd_alive(6,4)=0 throughout.
6. Reset mid-COMPUTE: assert rst_n=0 at cycle 8 of COMPUTE -> busy=0, gen_count=0, and every rd_alive read returns 0 immediately (asynchronous).
